// File: rtl/bl_i2c_pkg.sv
// ---------------------------------------------------------------------------
// bl_i2c_pkg
// Shared types for the backlight I2C writer:
//   state_t   - transaction FSM states
//   qphase_t  - SCL quarter-period index within one bit slot
//   FRAME_LEN - data bytes per frame (address, register, pwm hi, pwm lo, enable)
// ---------------------------------------------------------------------------
package bl_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BYTE  = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        Q0 = 2'd0,   // SCL low, SDA may change
        Q1 = 2'd1,   // SCL released (rising)
        Q2 = 2'd2,   // SCL high, ACK sampled at the end
        Q3 = 2'd3    // SCL pulled low
    } qphase_t;

    localparam int unsigned FRAME_LEN = 5;

endpackage

// File: rtl/bl_i2c_writer_qtick.sv
// ---------------------------------------------------------------------------
// i2c_qtick
// Quarter-period tick generator for the I2C bit engine. Counts 0..QDIV-1 and
// advances the quarter index on every wrap. While hold_i is high the count
// freezes (SCL clock stretching by the slave).
// Ports:
//   clk_i      system clock
//   reset_n_i  synchronous reset, active low
//   clr_i      restart at quarter 0, count 0
//   hold_i     freeze the divider
//   tick_o     high in the last cycle of the current quarter
//   q_o        current quarter index
// ---------------------------------------------------------------------------
module i2c_qtick
    import bl_i2c_pkg::*;
#(
    parameter int unsigned QDIV = 250
) (
    input  logic    clk_i,
    input  logic    reset_n_i,
    input  logic    clr_i,
    input  logic    hold_i,
    output logic    tick_o,
    output qphase_t q_o
);

    localparam int unsigned CW = (QDIV > 1) ? $clog2(QDIV) : 1;

    logic [CW-1:0] r_cnt;
    qphase_t       r_q;
    logic          w_last;

    assign w_last = (r_cnt == CW'(QDIV - 1));
    // clr_i is deliberately kept out of the tick so the caller may use the
    // tick to decide when to clear without forming a combinational loop.
    assign tick_o = w_last && !hold_i;
    assign q_o    = r_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i || clr_i) begin
            r_cnt <= '0;
            r_q   <= Q0;
        end else if (!hold_i) begin
            if (w_last) begin
                r_cnt <= '0;
                r_q   <= qphase_t'(r_q + 2'd1);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bl_i2c_writer.sv
// ---------------------------------------------------------------------------
// bl_i2c_writer
// Writes {enable, pwm} to an external I2C backlight driver as one
// auto-increment register write: START, {DEV_ADDR,W}, REG_BASE, pwm[15:8],
// pwm[7:0], {7'b0,en}, STOP. Loads arriving during a transaction coalesce
// into a single pending slot; a NACK triggers up to RETRIES re-sends.
// Ports:
//   clk_i, reset_n_i     clock, synchronous active-low reset
//   load_i               strobe: capture enable_i / pwm_i
//   enable_i, pwm_i      data to send
//   scl_i, sda_i         pad inputs (stretch detect, ACK sampling)
//   scl_oe_o, sda_oe_o   1 = pull line low
//   busy_o               transaction in progress
//   done_o               pulse: frame fully ACKed
//   nack_o               pulse: retries exhausted
// ---------------------------------------------------------------------------
module bl_i2c_writer
    import bl_i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = 7'h2C,
    parameter logic [7:0]  REG_BASE = 8'h00,
    parameter int unsigned QDIV     = 250,
    parameter int unsigned RETRIES  = 3
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        load_i,
    input  logic        enable_i,
    input  logic [15:0] pwm_i,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        scl_oe_o,
    output logic        sda_oe_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        nack_o
);

    localparam int unsigned RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

    state_t          r_state;
    logic [2:0]      r_byte;
    logic [2:0]      r_bit;
    logic            r_stop2;      // second pass of STOP: bus-free time
    logic            r_err;
    logic            r_ack_nak;
    logic [RW-1:0]   r_retry;
    logic            r_pend;
    logic [16:0]     r_pend_data;  // {enable, pwm}
    logic [16:0]     r_data;
    logic            r_scl_oe;
    logic            r_sda_oe;
    logic            r_done;
    logic            r_nack;

    logic            w_tick;
    qphase_t         w_q;
    logic            w_hold;
    logic            w_qclr;
    logic            w_stop_exit;
    logic            w_retry;
    logic            w_take;
    logic [7:0]      w_byte_val;
    logic            w_scl_oe;
    logic            w_sda_oe;

    // The slave may stretch only while we have released SCL.
    assign w_hold = ((w_q == Q1) || (w_q == Q2)) && !r_scl_oe && !scl_i;
    assign w_stop_exit = (r_state == ST_STOP) && r_stop2 && w_tick;
    assign w_retry     = w_stop_exit && r_err && (r_retry < RW'(RETRIES));
    assign w_take      = ((r_state == ST_IDLE) && r_pend) || (w_retry && r_pend);
    // Every transaction (including a retry) starts from a fresh quarter 0.
    assign w_qclr      = (r_state == ST_IDLE) || w_stop_exit;

    i2c_qtick #(.QDIV(QDIV)) u_qtick (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clr_i     (w_qclr),
        .hold_i    (w_hold),
        .tick_o    (w_tick),
        .q_o       (w_q)
    );

    always_comb begin
        case (r_byte)
            3'd0:    w_byte_val = {DEV_ADDR, 1'b0};
            3'd1:    w_byte_val = REG_BASE;
            3'd2:    w_byte_val = r_data[15:8];
            3'd3:    w_byte_val = r_data[7:0];
            default: w_byte_val = {7'b0, r_data[16]};
        endcase
    end

    // Line drive per state and quarter; registered below so the pads are glitch-free.
    always_comb begin
        w_scl_oe = 1'b0;
        w_sda_oe = 1'b0;
        case (r_state)
            ST_START: begin
                w_sda_oe = 1'b1;
                w_scl_oe = (w_q == Q2) || (w_q == Q3);
            end
            ST_BYTE: begin
                w_sda_oe = ~w_byte_val[r_bit];
                w_scl_oe = (w_q == Q0) || (w_q == Q3);
            end
            ST_ACK: begin
                w_scl_oe = (w_q == Q0) || (w_q == Q3);
            end
            ST_STOP: begin
                // q0: both low, q1-q2: SCL released, q3 and second-pass q0: bus free
                if (!r_stop2) begin
                    w_scl_oe = (w_q == Q0);
                    w_sda_oe = (w_q != Q3);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state     <= ST_IDLE;
            r_byte      <= '0;
            r_bit       <= '0;
            r_stop2     <= 1'b0;
            r_err       <= 1'b0;
            r_ack_nak   <= 1'b0;
            r_retry     <= '0;
            r_pend      <= 1'b0;
            r_pend_data <= '0;
            r_data      <= '0;
            r_scl_oe    <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_done      <= 1'b0;
            r_nack      <= 1'b0;
        end else begin
            r_scl_oe <= w_scl_oe;
            r_sda_oe <= w_sda_oe;
            r_done   <= 1'b0;
            r_nack   <= 1'b0;

            // A load in the same cycle as a consume wins.
            if (load_i) begin
                r_pend      <= 1'b1;
                r_pend_data <= {enable_i, pwm_i};
            end else if (w_take) begin
                r_pend <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_pend) begin
                        r_state <= ST_START;
                        r_data  <= r_pend_data;
                    end
                end
                ST_START: begin
                    if (w_tick && (w_q == Q3)) begin
                        r_state <= ST_BYTE;
                        r_byte  <= '0;
                        r_bit   <= 3'd7;
                        r_err   <= 1'b0;
                    end
                end
                ST_BYTE: begin
                    if (w_tick && (w_q == Q3)) begin
                        if (r_bit == 3'd0) begin
                            r_state <= ST_ACK;
                        end else begin
                            r_bit <= r_bit - 3'd1;
                        end
                    end
                end
                ST_ACK: begin
                    if (w_tick && (w_q == Q2)) begin
                        r_ack_nak <= sda_i;
                    end
                    if (w_tick && (w_q == Q3)) begin
                        if (r_ack_nak) begin
                            r_err   <= 1'b1;
                            r_state <= ST_STOP;
                            r_stop2 <= 1'b0;
                        end else if (r_byte == 3'(FRAME_LEN - 1)) begin
                            r_state <= ST_STOP;
                            r_stop2 <= 1'b0;
                        end else begin
                            r_byte  <= r_byte + 3'd1;
                            r_bit   <= 3'd7;
                            r_state <= ST_BYTE;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick && !r_stop2 && (w_q == Q3)) begin
                        r_stop2 <= 1'b1;
                    end else if (w_stop_exit) begin
                        if (!r_err) begin
                            r_done  <= 1'b1;
                            r_retry <= '0;
                            r_state <= ST_IDLE;
                        end else if (w_retry) begin
                            r_retry <= r_retry + 1'b1;
                            r_state <= ST_START;
                            // A newer value supersedes the one that was NACKed.
                            if (r_pend) begin
                                r_data <= r_pend_data;
                            end
                        end else begin
                            r_nack  <= 1'b1;
                            r_retry <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign scl_oe_o = r_scl_oe;
    assign sda_oe_o = r_sda_oe;
    assign busy_o   = (r_state != ST_IDLE);
    assign done_o   = r_done;
    assign nack_o   = r_nack;

endmodule
